// File: rtl/hex_scan_controller_cc.sv
// hex_scan_controller_cc
//   Time-multiplexed scan controller for an N-digit common-cathode 7-segment
//   display. The host frame (hex nibbles + decimal points) lands in a pending
//   buffer and is committed to the shadow (displayed) buffer only at a frame
//   boundary, so a frame never tears. Each digit slot starts with a guard
//   blanking interval (all digits deselected) to suppress ghosting.
//
// Ports
//   CLK, RST    : clock, synchronous active-high reset
//   HEX_in      : frame nibbles, digit i = HEX_in[4i+3:4i], digit 0 rightmost
//   dp_in       : decimal point per digit, active high
//   load        : capture HEX_in/dp_in into the pending buffer
//   lz_en       : leading-zero blanking enable, sampled at commit
//   Segments    : gfedcba, active high, registered
//   dp          : decimal point of the selected digit, registered
//   SEL         : digit selects, active low, registered
//   load_ack    : one-cycle pulse after a commit
//   frame_tick  : one-cycle pulse after every frame boundary
module hex_scan_controller_cc #(
    parameter int DIGITS       = 4,
    parameter int PRESCALE     = 50000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [4*DIGITS-1:0]   HEX_in,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic                  load,
    input  logic                  lz_en,
    output logic [6:0]            Segments,
    output logic                  dp,
    output logic [DIGITS-1:0]     SEL,
    output logic                  load_ack,
    output logic                  frame_tick
);

    localparam int CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PRESCALE - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

    logic [CNT_W-1:0]           cnt;
    logic [IDX_W-1:0]           idx;
    logic [DIGITS-1:0][3:0]     pend_hex, shad_hex;
    logic [DIGITS-1:0]          pend_dp, shad_dp;
    logic                       pend_valid;
    logic                       lz;

    logic slot_end, frame_end, in_blank, commit;

    assign slot_end  = (cnt == CNT_LAST);
    assign frame_end = slot_end && (idx == IDX_LAST);
    assign in_blank  = (int'(cnt) < BLANK_CYCLES);
    // A load on the boundary edge itself is enough to commit (bypass path).
    assign commit    = frame_end && (pend_valid || load);

    function automatic logic [6:0] decode(input logic [3:0] h);
        case (h)
            4'h0: decode = 7'b0111111;
            4'h1: decode = 7'b0000110;
            4'h2: decode = 7'b1011011;
            4'h3: decode = 7'b1001111;
            4'h4: decode = 7'b1100110;
            4'h5: decode = 7'b1101101;
            4'h6: decode = 7'b1111101;
            4'h7: decode = 7'b0000111;
            4'h8: decode = 7'b1111111;
            4'h9: decode = 7'b1101111;
            4'hA: decode = 7'b1110111;
            4'hB: decode = 7'b1111100;
            4'hC: decode = 7'b0111001;
            4'hD: decode = 7'b1011110;
            4'hE: decode = 7'b1111001;
            default: decode = 7'b1110001;
        endcase
    endfunction

    // Slot / digit scan counters.
    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt <= '0;
            idx <= '0;
        end else if (slot_end) begin
            cnt <= '0;
            idx <= frame_end ? '0 : idx + 1'b1;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Pending / shadow double buffer and boundary pulses.
    always_ff @(posedge CLK) begin
        if (RST) begin
            pend_hex   <= '0;
            pend_dp    <= '0;
            pend_valid <= 1'b0;
            shad_hex   <= '0;
            shad_dp    <= '0;
            lz         <= 1'b0;
            load_ack   <= 1'b0;
            frame_tick <= 1'b0;
        end else begin
            if (load) begin
                pend_hex <= HEX_in;
                pend_dp  <= dp_in;
            end
            if (commit) begin
                shad_hex   <= load ? HEX_in : pend_hex;
                shad_dp    <= load ? dp_in  : pend_dp;
                lz         <= lz_en;
                pend_valid <= 1'b0;
            end else if (load) begin
                pend_valid <= 1'b1;
            end
            load_ack   <= commit;
            frame_tick <= frame_end;
        end
    end

    // zero_above[i]: digit i and every higher digit have nibble 0 and dp 0.
    logic [DIGITS:0]   zero_above;
    logic [DIGITS-1:0] lz_blank;

    assign zero_above[DIGITS] = 1'b1;
    for (genvar i = 0; i < DIGITS; i++) begin : g_lz
        assign zero_above[i] = zero_above[i+1] && (shad_hex[i] == 4'h0) && !shad_dp[i];
        if (i == 0) begin : g_d0
            assign lz_blank[i] = 1'b0;
        end else begin : g_dn
            assign lz_blank[i] = lz && zero_above[i];
        end
    end

    // Registered display drive; SEL still strobes a leading-zero-blanked
    // digit so every digit sees the same duty cycle.
    always_ff @(posedge CLK) begin
        if (RST || in_blank) begin
            Segments <= '0;
            dp       <= 1'b0;
            SEL      <= '1;
        end else begin
            Segments <= lz_blank[idx] ? 7'b0 : decode(shad_hex[idx]);
            dp       <= shad_dp[idx];
            SEL      <= ~(DIGITS'(1) << idx);
        end
    end

endmodule
